// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_queue_pkg;

    typedef enum logic [1:0] {
        FQ_IDLE  = 2'd0,
        FQ_ISSUE = 2'd1,
        FQ_DROP  = 2'd2
    } fq_state_t;

    localparam logic [31:0] NOP_INST = 32'h0;
    localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: imem request/ack, redirect, IF/ID dequeue and head-of-queue outputs.
// master = fetch queue, slave = surrounding pipeline and instruction memory.
interface fetch_queue_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
);
    logic                     start_i;
    logic                     imem_req_o;
    logic [ADDR_W-1:0]        imem_addr_o;
    logic                     imem_ack_i;
    logic [DATA_W-1:0]        imem_data_i;
    logic                     redirect_i;
    logic [ADDR_W-1:0]        redirect_pc_i;
    logic                     deq_i;
    logic                     inst_valid_o;
    logic [DATA_W-1:0]        inst_o;
    logic [ADDR_W-1:0]        pc_plus4_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport master (
        input  start_i, imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, deq_i,
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_plus4_o, count_o
    );

    modport slave (
        output start_i, imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, deq_i,
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_plus4_o, count_o
    );
endinterface

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry FIFO with synchronous flush (flush beats push/pop).
// Latency: push visible at head next cycle. Backpressure: push ignored when full without a pop.
// Pop while empty is ignored.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are PTR_W bits wide, so DEPTH being a power of two gives free wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: fetch PC, single-outstanding imem requests, prefetch FIFO of {inst, pc+4}.
// Latency: start -> req next cycle; ack -> inst_valid next cycle. Backpressure: no issue while FIFO full.
// FQ_PERF_EN adds saturating perf_flush_o / perf_stall_o counters.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    fetch_queue_if.master  fq
`ifdef FQ_PERF_EN
    ,
    output logic [15:0]    perf_flush_o,
    output logic [15:0]    perf_stall_o
`endif
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned WIDTH = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fq_state_t         state;
    fq_state_t         state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] drop_addr;
    logic [ADDR_W-1:0] pc_next4;
    logic [WIDTH-1:0]  fifo_rdata;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after;
    logic              fifo_valid;
    logic              ack_push;
    logic              pop_eff;

    assign pc_next4    = fetch_pc + ADDR_W'(PC_STEP);
    assign fifo_valid  = (count != '0);
    assign ack_push    = (state == FQ_ISSUE) && fq.imem_ack_i && !fq.redirect_i;
    assign pop_eff     = fq.deq_i && fifo_valid && !fq.redirect_i;
    assign count_after = count + CNT_W'(ack_push) - CNT_W'(pop_eff);

    fetch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (ack_push),
        .pop   (fq.deq_i),
        .flush (fq.redirect_i),
        .wdata ({fq.imem_data_i, pc_next4}),
        .rdata (fifo_rdata),
        .count (count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= FQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An issued request cannot be withdrawn, so a redirect while it is in flight parks in DROP.
    always_comb begin
        state_nxt = state;
        case (state)
            FQ_IDLE: begin
                if (fq.start_i && (count < CNT_W'(DEPTH))) state_nxt = FQ_ISSUE;
            end
            FQ_ISSUE: begin
                if (fq.redirect_i && fq.imem_ack_i) begin
                    state_nxt = FQ_IDLE;
                end else if (fq.redirect_i) begin
                    state_nxt = FQ_DROP;
                end else if (fq.imem_ack_i) begin
                    state_nxt = (fq.start_i && (count_after < CNT_W'(DEPTH))) ? FQ_ISSUE : FQ_IDLE;
                end
            end
            FQ_DROP: begin
                if (fq.imem_ack_i) state_nxt = FQ_IDLE;
            end
            default: state_nxt = FQ_IDLE;
        endcase
    end

    always_comb begin
        fq.imem_req_o   = (state != FQ_IDLE);
        fq.imem_addr_o  = (state == FQ_DROP) ? drop_addr : fetch_pc;
        fq.inst_valid_o = fifo_valid;
        fq.inst_o       = DATA_W'(NOP_INST);
        fq.pc_plus4_o   = '0;
        fq.count_o      = count;
        if (fifo_valid) begin
            fq.inst_o     = fifo_rdata[WIDTH-1:ADDR_W];
            fq.pc_plus4_o = fifo_rdata[ADDR_W-1:0];
        end
    end

    // drop_addr keeps the abandoned request's address on the bus while fetch_pc follows redirects.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc  <= RESET_PC & ALIGN_MASK;
            drop_addr <= RESET_PC & ALIGN_MASK;
        end else begin
            if (fq.redirect_i) begin
                fetch_pc <= fq.redirect_pc_i & ALIGN_MASK;
            end else if (ack_push) begin
                fetch_pc <= pc_next4;
            end
            if ((state == FQ_ISSUE) && fq.redirect_i) begin
                drop_addr <= fetch_pc;
            end
        end
    end

`ifdef FQ_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_flush_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (fq.redirect_i && (perf_flush_o != 16'hFFFF)) begin
                perf_flush_o <= perf_flush_o + 16'd1;
            end
            if (!fifo_valid && fq.start_i && (perf_stall_o != 16'hFFFF)) begin
                perf_stall_o <= perf_stall_o + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-programmable imem model and an output scoreboard.
`timescale 1ns/1ps
module tb_fetch_queue;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) fq ();

`ifdef FQ_PERF_EN
    logic [15:0] perf_flush;
    logic [15:0] perf_stall;
`endif

    fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .fq    (fq)
`ifdef FQ_PERF_EN
        ,
        .perf_flush_o (perf_flush),
        .perf_stall_o (perf_stall)
`endif
    );

    int          tests = 0;
    int          fails = 0;
    logic [63:0] sb[$];
    int          lat = 1;
    int          cyc = 0;
    bit          rate_chk = 1'b0;
    int          prev_pop = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [63:0] exp_pair(input logic [31:0] a);
        return {mem_word(a), a + 32'd4};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction memory: acks `lat` cycles after it first sees a request.
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.imem_ack_i  <= 1'b0;
            fq.imem_data_i <= '0;
            mem_busy       <= 1'b0;
            mem_cnt        <= 0;
            mem_addr       <= '0;
        end else if (fq.imem_ack_i) begin
            fq.imem_ack_i <= 1'b0;
            mem_busy      <= 1'b0;
        end else if (mem_busy) begin
            if (mem_cnt <= 1) begin
                fq.imem_ack_i  <= 1'b1;
                fq.imem_data_i <= mem_word(mem_addr);
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end else if (fq.imem_req_o) begin
            mem_addr <= fq.imem_addr_o;
            if (lat <= 1) begin
                fq.imem_ack_i  <= 1'b1;
                fq.imem_data_i <= mem_word(fq.imem_addr_o);
            end else begin
                mem_busy <= 1'b1;
                mem_cnt  <= lat - 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && fq.inst_valid_o && fq.deq_i && !fq.redirect_i) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_pop: got %0h expected nothing", {fq.inst_o, fq.pc_plus4_o});
            end else begin
                check("pair", {fq.inst_o, fq.pc_plus4_o}, sb.pop_front());
                if (rate_chk) begin
                    if (prev_pop >= 0) check("rate", 64'(cyc - prev_pop), 64'd2);
                    prev_pop = cyc;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        fq.start_i = 1'b0; fq.redirect_i = 1'b0; fq.redirect_pc_i = '0; fq.deq_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_count(input int n, input int budget, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while ((int'(fq.count_o) != n) && (k < budget));
        check(tag, 64'(fq.count_o), 64'(n));
    endtask

    task automatic wait_req_addr(input logic [31:0] a, input int budget, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (!(fq.imem_req_o && fq.imem_addr_o == a) && (k < budget));
        check(tag, 64'({fq.imem_req_o, fq.imem_addr_o}), 64'({1'b1, a}));
    endtask

    task automatic wait_ack(input int budget, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (!fq.imem_ack_i && (k < budget));
        check(tag, 64'(fq.imem_ack_i), 64'd1);
    endtask

    // Drops start_i in the cycle the ack for address `a` arrives, so that word is the last one fetched.
    task automatic stop_after(input logic [31:0] a, input int budget, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end
        while (!(fq.imem_req_o && fq.imem_ack_i && fq.imem_addr_o == a) && (k < budget));
        fq.start_i = 1'b0;
        check(tag, 64'({fq.imem_req_o, fq.imem_ack_i, fq.imem_addr_o}), 64'({2'b11, a}));
    endtask

    task automatic drain(input int budget, input string tag);
        int k = 0;
        fq.deq_i = 1'b1;
        while ((sb.size() != 0) && (k < budget)) begin @(negedge clk); k++; end
        check(tag, 64'(sb.size()), 64'd0);
        @(negedge clk);
        check({tag, "_cnt"}, 64'(fq.count_o), 64'd0);
    endtask

    initial begin
        fq.start_i = 1'b0; fq.redirect_i = 1'b0; fq.redirect_pc_i = '0; fq.deq_i = 1'b0;
        @(negedge clk);
        check("rst_req",   64'(fq.imem_req_o),   64'd0);
        check("rst_addr",  64'(fq.imem_addr_o),  64'd0);
        check("rst_valid", 64'(fq.inst_valid_o), 64'd0);
        check("rst_inst",  64'(fq.inst_o),       64'd0);
        check("rst_pc4",   64'(fq.pc_plus4_o),   64'd0);
        check("rst_count", 64'(fq.count_o),      64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1-cycle memory, continuous dequeue: one instruction every 2 cycles.
        lat = 1; fq.deq_i = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back(exp_pair(32'(i * 4)));
        rate_chk = 1'b1; prev_pop = -1;
        @(posedge clk); #1 fq.start_i = 1'b1;
        @(negedge clk); check("t1_req_c0",   64'(fq.imem_req_o),   64'd0);
        @(negedge clk); check("t1_req_c1",   64'(fq.imem_req_o),   64'd1);
                        check("t1_addr_c1",  64'(fq.imem_addr_o),  64'd0);
        @(negedge clk); check("t1_valid_c2", 64'(fq.inst_valid_o), 64'd0);
        @(negedge clk); check("t1_valid_c3", 64'(fq.inst_valid_o), 64'd1);
        stop_after(32'h1C, 40, "t1_stop");
        drain(40, "t1_drain");
        rate_chk = 1'b0;

        // Stalled IF/ID: FIFO fills, no further requests, resume at 0x10.
        do_reset();
        lat = 1; fq.deq_i = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back(exp_pair(32'(i * 4)));
        @(posedge clk); #1 fq.start_i = 1'b1;
        wait_count(4, 30, "t2_full");
        begin
            bit saw_req = 1'b0;
            repeat (5) begin @(negedge clk); if (fq.imem_req_o) saw_req = 1'b1; end
            check("t2_no_req", 64'(saw_req), 64'd0);
        end
        check("t2_head", {fq.inst_o, fq.pc_plus4_o}, exp_pair(32'h0));
        for (int i = 4; i < 8; i++) sb.push_back(exp_pair(32'(i * 4)));
        @(posedge clk); #1 fq.deq_i = 1'b1;
        wait_req_addr(32'h10, 10, "t2_resume");
        stop_after(32'h1C, 40, "t2_stop");
        drain(40, "t2_drain");

        // Redirect while the request at 0x8 is in flight; a second redirect in DROP retargets.
        do_reset();
        lat = 3; fq.deq_i = 1'b1;
        sb.push_back(exp_pair(32'h0));
        sb.push_back(exp_pair(32'h4));
        sb.push_back(exp_pair(32'h100));
        @(posedge clk); #1 fq.start_i = 1'b1;
        wait_req_addr(32'h8, 40, "t3_req8");
        @(posedge clk); #1 fq.redirect_i = 1'b1; fq.redirect_pc_i = 32'h80;
        @(posedge clk); #1 fq.redirect_pc_i = 32'h100;
        @(negedge clk);
        check("t3_drop_req",  64'(fq.imem_req_o),  64'd1);
        check("t3_drop_addr", 64'(fq.imem_addr_o), 64'h8);
        @(posedge clk); #1 fq.redirect_i = 1'b0;
        wait_ack(10, "t3_drop_ack");
        @(negedge clk); check("t3_idle_req", 64'(fq.imem_req_o), 64'd0);
        @(negedge clk); check("t3_new_req", 64'({fq.imem_req_o, fq.imem_addr_o}), 64'({1'b1, 32'h100}));
        stop_after(32'h100, 20, "t3_stop");
        drain(20, "t3_drain");

        // Redirect coinciding with an ack: data dropped, FIFO flushed, low PC bits ignored.
        do_reset();
        lat = 2; fq.deq_i = 1'b0;
        @(posedge clk); #1 fq.start_i = 1'b1;
        wait_count(1, 20, "t4_one");
        wait_ack(10, "t4_ack");
        fq.redirect_i = 1'b1; fq.redirect_pc_i = 32'h202;
        @(posedge clk); #1 fq.redirect_i = 1'b0;
        sb.push_back(exp_pair(32'h200));
        @(negedge clk);
        check("t4_count", 64'(fq.count_o),      64'd0);
        check("t4_valid", 64'(fq.inst_valid_o), 64'd0);
        check("t4_req",   64'(fq.imem_req_o),   64'd0);
        @(negedge clk); check("t4_new_req", 64'({fq.imem_req_o, fq.imem_addr_o}), 64'({1'b1, 32'h200}));
        fq.deq_i = 1'b1;
        stop_after(32'h200, 20, "t4_stop");
        drain(20, "t4_drain");

        // Asynchronous reset in the middle of an outstanding request.
        do_reset();
        lat = 3; fq.deq_i = 1'b0;
        @(posedge clk); #1 fq.start_i = 1'b1;
        wait_count(1, 20, "t5_one");
        #2 rst = 1'b1;
        #1;
        check("t5_req",   64'(fq.imem_req_o),   64'd0);
        check("t5_addr",  64'(fq.imem_addr_o),  64'd0);
        check("t5_valid", 64'(fq.inst_valid_o), 64'd0);
        check("t5_inst",  64'(fq.inst_o),       64'd0);
        check("t5_count", 64'(fq.count_o),      64'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        sb.push_back(exp_pair(32'h0));
        fq.deq_i = 1'b1;
        wait_req_addr(32'h0, 10, "t5_restart");
        stop_after(32'h0, 20, "t5_stop");
        drain(20, "t5_drain");

`ifdef FQ_PERF_EN
        do_reset();
        @(negedge clk);
        check("t6_rst_flush", 64'(perf_flush), 64'd0);
        check("t6_rst_stall", 64'(perf_stall), 64'd0);
        lat = 20;
        @(posedge clk); #1 fq.redirect_i = 1'b1; fq.redirect_pc_i = 32'h40;
        repeat (3) @(posedge clk);
        #1 fq.redirect_i = 1'b0; fq.start_i = 1'b1;
        repeat (5) @(posedge clk);
        #1 fq.start_i = 1'b0;
        @(negedge clk);
        check("t6_flush", 64'(perf_flush), 64'd3);
        check("t6_stall", 64'(perf_stall), 64'd5);
        do_reset();
        lat = 70000;
        @(posedge clk); #1 fq.start_i = 1'b1;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("t6_sat_stall", 64'(perf_stall), 64'hFFFF);
        check("t6_sat_flush", 64'(perf_flush), 64'd0);
`endif

        do_reset();
        check("end_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
